// File: rtl/sdram_buf_mover_if.sv
// rtl/sdram_buf_mover_if.sv - command, buffer-port and SDRAM-port bundle for the buffer/SDRAM word mover
interface sdram_buf_mover_if #(
    parameter int SDR_BUSWIDTH = 32,
    parameter int BUF_ADRWID   = 10,
    parameter int SDR_ADRWID   = 24,
    parameter int LEN_WID      = 10
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [BUF_ADRWID-1:0]   cmd_bufaddr;
    logic [SDR_ADRWID-1:0]   cmd_sdraddr;
    logic [LEN_WID-1:0]      cmd_len;
    logic                    buf_ce;
    logic                    buf_we;
    logic [BUF_ADRWID-1:0]   buf_addr;
    logic [SDR_BUSWIDTH-1:0] buf_datao;
    logic [SDR_BUSWIDTH-1:0] buf_datai;
    logic                    mem_req;
    logic                    mem_we;
    logic [SDR_ADRWID-1:0]   mem_addr;
    logic [SDR_BUSWIDTH-1:0] mem_wdata;
    logic                    mem_ack;
    logic                    mem_rvalid;
    logic [SDR_BUSWIDTH-1:0] mem_rdata;
    logic                    busy;
    logic                    done;

    // The mover itself
    modport master (
        input  cmd_valid, cmd_dir, cmd_bufaddr, cmd_sdraddr, cmd_len,
        input  buf_datai, mem_ack, mem_rvalid, mem_rdata,
        output cmd_ready, buf_ce, buf_we, buf_addr, buf_datao,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );

    // Command source, buffer RAM and SDRAM controller around the mover
    modport slave (
        output cmd_valid, cmd_dir, cmd_bufaddr, cmd_sdraddr, cmd_len,
        output buf_datai, mem_ack, mem_rvalid, mem_rdata,
        input  cmd_ready, buf_ce, buf_we, buf_addr, buf_datao,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/sdram_buf_mover.sv
// rtl/sdram_buf_mover.sv - word-by-word mover between a buffer RAM and SDRAM; SDR_BUF_BSWAP_EN enables byte reversal
module sdram_buf_mover #(
    parameter int SDR_BUSWIDTH = 32,
    parameter int BUF_ADRWID   = 10,
    parameter int SDR_ADRWID   = 24,
    parameter int LEN_WID      = 10
) (
    input  logic               sdr_clk,
    input  logic               sys_rst,
    sdram_buf_mover_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, BUF_RD, BUF_WAIT, MEM_WR, MEM_RD, MEM_WAIT, BUF_WR, DONE
    } state_t;

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    buf_ce_q;
    logic                    buf_we_q;
    logic [BUF_ADRWID-1:0]   buf_addr_q;
    logic [SDR_BUSWIDTH-1:0] buf_datao_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [SDR_ADRWID-1:0]   mem_addr_q;
    logic [SDR_BUSWIDTH-1:0] mem_wdata_q;
    logic [LEN_WID-1:0]      cnt_q;
    logic [LEN_WID-1:0]      cnt_d;
    logic [BUF_ADRWID-1:0]   buf_addr_d;
    logic [SDR_ADRWID-1:0]   mem_addr_d;

    // Word data crossing between the two ports, optionally byte-reversed
    function automatic logic [SDR_BUSWIDTH-1:0] xform(input logic [SDR_BUSWIDTH-1:0] w);
        logic [SDR_BUSWIDTH-1:0] r;
`ifdef SDR_BUF_BSWAP_EN
        r = '0;
        for (int i = 0; i < SDR_BUSWIDTH / 8; i++) begin
            r[8*i +: 8] = w[SDR_BUSWIDTH - 8 - 8*i +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    // Post-word count and addresses; natural width overflow gives the modulo wrap
    assign cnt_d      = cnt_q - LEN_WID'(1);
    assign buf_addr_d = buf_addr_q + BUF_ADRWID'(1);
    assign mem_addr_d = mem_addr_q + SDR_ADRWID'(1);

    // Transfer sequencer; every output is a register set on entry to the state that owns it
    always_ff @(posedge sdr_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buf_ce_q    <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_datao_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        buf_addr_q  <= bus.cmd_bufaddr;
                        mem_addr_q  <= bus.cmd_sdraddr;
                        cnt_q       <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (!bus.cmd_dir) begin
                            state_q  <= BUF_RD;
                            buf_ce_q <= 1'b1;
                            buf_we_q <= 1'b0;
                        end else begin
                            state_q   <= MEM_RD;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                BUF_RD: begin
                    buf_ce_q <= 1'b0;
                    state_q  <= BUF_WAIT;
                end
                BUF_WAIT: begin
                    // Registered buffer output is valid by the end of this cycle
                    mem_wdata_q <= xform(bus.buf_datai);
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    state_q     <= MEM_WR;
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        cnt_q      <= cnt_d;
                        buf_addr_q <= buf_addr_d;
                        mem_addr_q <= mem_addr_d;
                        if (cnt_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= BUF_RD;
                            buf_ce_q <= 1'b1;
                        end
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_rvalid) begin
                        buf_datao_q <= xform(bus.mem_rdata);
                        buf_ce_q    <= 1'b1;
                        buf_we_q    <= 1'b1;
                        state_q     <= BUF_WR;
                    end
                end
                BUF_WR: begin
                    buf_ce_q   <= 1'b0;
                    buf_we_q   <= 1'b0;
                    cnt_q      <= cnt_d;
                    buf_addr_q <= buf_addr_d;
                    mem_addr_q <= mem_addr_d;
                    if (cnt_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= MEM_RD;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.buf_ce    = buf_ce_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_datao = buf_datao_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
